mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
Load/store stage sitting directly upstream of the word-wide data memory. Accepts one memory request at a time from the execute stage via valid/ready. Drives the memory's rw/location/data pins, captures the returned word, and hands a result to writeback via valid/ready. The memory is word-only, so byte and halfword stores are performed as read-modify-write, and loads are extracted and extended here.

Parameters:
ADDR_W, 10, word-address width driven to memory (1024 words)
DATA_W, 32, data word width; fixed at 32 for byte-lane logic
RD_LAT, 1, cycles from read issue to valid mem_rdata (1..4)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept request (high only in IDLE)
req_we  in  1  1=store, 0=load
req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
req_signed  in  1  loads: 1=sign-extend, 0=zero-extend
req_addr  in  ADDR_W+2  byte address
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  response present
rsp_ready  in  1  writeback accepts response
rsp_rdata  out  32  extended load data; 0 for stores
rsp_err  out  1  misaligned or illegal size; no memory access made
mem_rw  out  1  0=read, 1=write
mem_location  out  ADDR_W  word address = req_addr[ADDR_W+1:2]
mem_data  out  32  write data to memory
mem_rdata  in  32  read data from memory

Behaviour:
- Reset (async, rst_n=0): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_rw=0, mem_location=0, mem_data=0, wait counter=0.
- mem_rw is 1 for exactly one cycle per write and is 0 at all other times.
- States: IDLE, RD_WAIT, WRITE, RESP.
- IDLE: when req_valid & req_ready, latch all req_* fields.
  - Error check: half with addr[0]=1, word with addr[1:0]!=0, or size=11 -> RESP with err=1 and rdata=0. No mem_rw pulse.
  - Word store -> WRITE.
  - Load or sub-word store -> drive mem_location, mem_rw=0, load counter=RD_LAT -> RD_WAIT.
- RD_WAIT: decrement the counter; at 0, sample mem_rdata.
  - Load: extract lane (byte lane = addr[1:0], half lane = addr[1]), extend per req_signed -> RESP.
  - Sub-word store: merge req_wdata low bits into the sampled lane, keep other bytes -> WRITE.
- WRITE: mem_rw=1, mem_location and mem_data held valid for the cycle; next -> RESP, rdata=0.
- RESP: rsp_valid=1 with rdata/err stable until rsp_ready; on handshake -> IDLE.
  - rsp_valid and req_ready are never both high; next request is accepted at the earliest in the cycle after the response handshake.
- Latency, rsp_ready held high:
  - word store: rsp_valid 2 cycles after accept
  - load: RD_LAT+1 cycles after accept
  - sub-word store: RD_LAT+2 cycles after accept
  - error: 1 cycle after accept
- Reset mid-operation: FSM returns to IDLE immediately, mem_rw drops to 0 asynchronously, and the latched request is discarded.
- Address wrap: none; the top word (location 1023) is legal. Address bits above ADDR_W+1 do not exist.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state enum
  - MEM_READ=0/MEM_WRITE=1 constants
  - ADDR_W default
- One sub-module, lane_align: purely combinational.
  - Load extraction/extension: inputs word, addr[1:0], size, signed.
  - Store merge: inputs old word, new data, addr[1:0], size.

Test Plan:
1. Word store 0xDEADBEEF @ byte addr 0x010 -> one mem_rw=1 pulse, location=4, data=0xDEADBEEF; rsp_valid 2 cycles after accept, err=0.
2. Memory word 4 = 0x8070F0AA, signed byte load @0x013 -> rdata=0xFFFFFF80; unsigned half load @0x012 -> 0x00008070; no mem_rw pulse on either.
3. Word 4 = 0x11223344, byte store 0xAB @0x011 -> single read, then one write of 0x1122AB44; RD_LAT=3 gives rsp_valid 5 cycles after accept.
4. Half load @0x001, word store @0x002, size=11 -> err=1, rdata=0, mem_rw never asserted, response 1 cycle after accept.
5. rsp_ready low for 4 cycles -> rsp_valid/rdata held stable, req_ready=0 throughout; request accepted only after the handshake.
6. rst_n pulled low during RD_WAIT and during WRITE -> outputs return to reset values without waiting for clk; first post-reset request completes normally at location 1023.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the load/store stage.
// Size codes, FSM states and memory strobe levels.
package mem_pkg;

  localparam int DEF_ADDR_W = 10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_WAIT,
    S_WRITE,
    S_RESP
  } state_e;

  function automatic logic bad_access(
    input logic [1:0] size,
    input logic [1:0] off
  );
    return (size == 2'b11) ||
           ((size == SZ_HALF) && off[0]) ||
           ((size == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane extraction for loads and lane merge for
// sub-word stores against a 32-bit memory word.
module lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        sgn_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b       = word_i[{off_i, 3'b000} +: 8];
    h       = off_i[1] ? word_i[31:16] : word_i[15:0];
    load_o  = word_i;
    store_o = wdata_i;
    unique case (1'b1)
      (size_i == SZ_BYTE): begin
        load_o  = {{24{sgn_i & b[7]}}, b};
        store_o = word_i;
        store_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      (size_i == SZ_HALF): begin
        load_o  = {{16{sgn_i & h[15]}}, h};
        store_o = word_i;
        store_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage in front of a word-only data memory.
// Sub-word stores are done as read-modify-write.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_location,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [1:0]        off_q, off_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] loc_q, loc_d;
  logic [DATA_W-1:0] mdata_q, mdata_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [31:0]       ld_word, st_word;

  lane_align u_lane (
    .word_i  (mem_rdata),
    .off_i   (off_q),
    .size_i  (size_q),
    .sgn_i   (sgn_q),
    .wdata_i (wdata_q),
    .load_o  (ld_word),
    .store_o (st_word)
  );

  assign req_ready    = (state_q == S_IDLE);
  assign rsp_valid    = (state_q == S_RESP);
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = err_q;
  assign mem_rw       = rw_q;
  assign mem_location = loc_q;
  assign mem_data     = mdata_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    loc_d   = loc_q;
    mdata_d = mdata_q;
    rw_d    = MEM_READ;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          sgn_d   = req_signed;
          off_d   = req_addr[1:0];
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          if (bad_access(req_size, req_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (req_we && req_size == SZ_WORD) begin
            loc_d   = req_addr[ADDR_W+1:2];
            mdata_d = req_wdata;
            rw_d    = MEM_WRITE;
            state_d = S_WRITE;
          end else begin
            loc_d   = req_addr[ADDR_W+1:2];
            cnt_d   = LAT;
            state_d = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_d == 3'd0) begin
          if (we_q) begin
            mdata_d = st_word;
            rw_d    = MEM_WRITE;
            state_d = S_WRITE;
          end else begin
            rdata_d = ld_word;
            state_d = S_RESP;
          end
        end
      end
      S_WRITE: begin
        rdata_d = '0;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      off_q   <= '0;
      wdata_q <= '0;
      loc_q   <= '0;
      mdata_q <= '0;
      rw_q    <= MEM_READ;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      loc_q   <= loc_d;
      mdata_q <= mdata_d;
      rw_q    <= rw_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule
